// File: rtl/cpu_run_monitor.sv
// Run monitor for the single-cycle RISC-V core: counts cycles and retired
// instructions, mirrors one register, detects end of program or timeout,
// and keeps a circular history of recent PCs for post-mortem reads.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   pc, instr    current PC and the instruction fetched at it
//   rf_we/_waddr/_wdata  register-file write port (observed only)
//   trace_idx    history read index, 0 = newest
//   trace_pc     PC at trace_idx (combinational)
//   cycle_count  cycles spent in RUN
//   instret      retired instructions (PC changes in RUN)
//   watch_value  shadow copy of register WATCH_REG
//   state        0 IDLE, 1 RUN, 2 HALTED, 3 TIMEOUT
//   done         state is HALTED or TIMEOUT
//   halt_cause   0 none, 1 ECALL, 2 EBREAK, 3 PC self-loop
//   pass, fail   golden-value verdict, present only with MON_EXPECT_EN
//
// Build option: define MON_EXPECT_EN to compare watch_value against
// EXPECT_VALUE when the program halts.
module cpu_run_monitor #(
   parameter int          XLEN         = 32,
   parameter int          WATCH_REG    = 11,
   parameter int          STALL_LIMIT  = 4,
   parameter int          TIMEOUT      = 50,
   parameter int          TRACE_DEPTH  = 8,
   parameter logic [XLEN-1:0] EXPECT_VALUE = '0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [XLEN-1:0]                pc,
   input  logic [31:0]                    instr,
   input  logic                           rf_we,
   input  logic [4:0]                     rf_waddr,
   input  logic [XLEN-1:0]                rf_wdata,
   input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
   output logic [XLEN-1:0]                trace_pc,
   output logic [31:0]                    cycle_count,
   output logic [31:0]                    instret,
   output logic [XLEN-1:0]                watch_value,
   output logic [1:0]                     state,
   output logic                           done,
   output logic [1:0]                     halt_cause
`ifdef MON_EXPECT_EN
   ,
   output logic                           pass,
   output logic                           fail
`endif
);

   localparam int AW = $clog2(TRACE_DEPTH);
   localparam logic [4:0] WREG = 5'(WATCH_REG);
   localparam logic [31:0] ECALL = 32'h0000_0073;
   localparam logic [31:0] EBREAK = 32'h0010_0073;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RUN     = 2'd1,
      S_HALTED  = 2'd2,
      S_TIMEOUT = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] prev_q, prev_d;
   logic [31:0]     cycle_q, cycle_d;
   logic [31:0]     inst_q, inst_d;
   logic [XLEN-1:0] watch_q, watch_d;
   logic [7:0]      stall_q, stall_d;
   logic [1:0]      cause_q, cause_d;
   logic [AW-1:0]   wp_q, wp_d;
   logic            hist_we;
   logic [XLEN-1:0] hist_q [TRACE_DEPTH];
   logic [AW-1:0]   rd_ptr;
   logic            pc_same;
   logic            wr_hit;
`ifdef MON_EXPECT_EN
   logic            pass_q, pass_d;
   logic            fail_q, fail_d;
`endif

   assign pc_same = (pc == prev_q);
   assign wr_hit  = rf_we && (rf_waddr == WREG) && (WREG != 5'd0);

   always_comb begin
      state_d = state_q;
      prev_d  = prev_q;
      cycle_d = cycle_q;
      inst_d  = inst_q;
      watch_d = watch_q;
      stall_d = stall_q;
      cause_d = cause_q;
      wp_d    = wp_q;
      hist_we = 1'b0;
`ifdef MON_EXPECT_EN
      pass_d  = pass_q;
      fail_d  = fail_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            prev_d  = pc;
            stall_d = 8'd0;
            if (wr_hit) watch_d = rf_wdata;
            state_d = S_RUN;
         end
         S_RUN: begin
            cycle_d = cycle_q + 32'd1;
            prev_d  = pc;
            if (wr_hit) watch_d = rf_wdata;
            if (!pc_same) begin
               inst_d  = inst_q + 32'd1;
               hist_we = 1'b1;
               wp_d    = wp_q + AW'(1);
               stall_d = 8'd0;
            end else if (stall_q != 8'hFF) begin
               stall_d = stall_q + 8'd1;
            end
            // Self-loop fires on the edge where the counter would
            // reach STALL_LIMIT-1, i.e. the (STALL_LIMIT-1)th repeat.
            if (instr == ECALL) begin
               state_d = S_HALTED;
               cause_d = 2'd1;
            end else if (instr == EBREAK) begin
               state_d = S_HALTED;
               cause_d = 2'd2;
            end else if (pc_same &&
                         stall_q == 8'(STALL_LIMIT - 2)) begin
               state_d = S_HALTED;
               cause_d = 2'd3;
            end else if (cycle_q == 32'(TIMEOUT - 1)) begin
               state_d = S_TIMEOUT;
            end
`ifdef MON_EXPECT_EN
            if (state_d == S_HALTED) begin
               pass_d = (watch_d == EXPECT_VALUE);
               fail_d = (watch_d != EXPECT_VALUE);
            end else if (state_d == S_TIMEOUT) begin
               fail_d = 1'b1;
            end
`endif
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         prev_q  <= '0;
         cycle_q <= '0;
         inst_q  <= '0;
         watch_q <= '0;
         stall_q <= '0;
         cause_q <= '0;
         wp_q    <= '0;
`ifdef MON_EXPECT_EN
         pass_q  <= 1'b0;
         fail_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         prev_q  <= prev_d;
         cycle_q <= cycle_d;
         inst_q  <= inst_d;
         watch_q <= watch_d;
         stall_q <= stall_d;
         cause_q <= cause_d;
         wp_q    <= wp_d;
`ifdef MON_EXPECT_EN
         pass_q  <= pass_d;
         fail_q  <= fail_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < TRACE_DEPTH; i++) hist_q[i] <= '0;
      end else if (hist_we) begin
         hist_q[wp_q] <= pc;
      end
   end

   // wp points at the next free slot, so the newest entry is wp-1.
   assign rd_ptr      = wp_q - AW'(1) - trace_idx;
   assign trace_pc    = hist_q[rd_ptr];
   assign cycle_count = cycle_q;
   assign instret     = inst_q;
   assign watch_value = watch_q;
   assign state       = state_q;
   assign done        = state_q[1];
   assign halt_cause  = cause_q;
`ifdef MON_EXPECT_EN
   assign pass        = pass_q;
   assign fail        = fail_q;
`endif

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Directed bench for cpu_run_monitor: a vector table for the main
// ECALL/watch run, plus hand sequences for stall, timeout and trace wrap.
module tb_cpu_run_monitor;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] ECL = 32'h0000_0073;
   localparam logic [31:0] EBK = 32'h0010_0073;
   localparam logic [31:0] IPC = 32'hFFFF_FFFC;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc = IPC;
   logic [31:0] instr = NOP;
   logic        rf_we = 1'b0;
   logic [4:0]  rf_waddr = 5'd0;
   logic [31:0] rf_wdata = 32'd0;
   logic [2:0]  trace_idx = 3'd0;

   logic [31:0] trace_pc, cycle_count, instret, watch_value;
   logic [1:0]  state, halt_cause;
   logic        done;
   logic [31:0] z_trace_pc, z_cycle, z_inst, z_watch;
   logic [1:0]  z_state, z_cause;
   logic        z_done;
`ifdef MON_EXPECT_EN
   logic        pass, fail, z_pass, z_fail;
`endif

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   cpu_run_monitor #(
      .XLEN(32), .WATCH_REG(11), .STALL_LIMIT(4), .TIMEOUT(50),
      .TRACE_DEPTH(8), .EXPECT_VALUE(32'd55)
   ) u_dut (
      .clk(clk), .rst(rst), .pc(pc), .instr(instr),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .trace_idx(trace_idx), .trace_pc(trace_pc),
      .cycle_count(cycle_count), .instret(instret),
      .watch_value(watch_value), .state(state), .done(done),
      .halt_cause(halt_cause)
`ifdef MON_EXPECT_EN
      , .pass(pass), .fail(fail)
`endif
   );

   cpu_run_monitor #(
      .XLEN(32), .WATCH_REG(0), .STALL_LIMIT(4), .TIMEOUT(50),
      .TRACE_DEPTH(8), .EXPECT_VALUE(32'd0)
   ) u_zero (
      .clk(clk), .rst(rst), .pc(pc), .instr(instr),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .trace_idx(trace_idx), .trace_pc(z_trace_pc),
      .cycle_count(z_cycle), .instret(z_inst),
      .watch_value(z_watch), .state(z_state), .done(z_done),
      .halt_cause(z_cause)
`ifdef MON_EXPECT_EN
      , .pass(z_pass), .fail(z_fail)
`endif
   );

   typedef struct {
      logic        r;
      logic [31:0] p;
      logic [31:0] ins;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [1:0]  st;
      logic [1:0]  cs;
      logic [31:0] cy;
      logic [31:0] rt;
      logic [31:0] wv;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic [31:0] p,
                       input logic [31:0] ins, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd);
      rst = r; pc = p; instr = ins;
      rf_we = we; rf_waddr = wa; rf_wdata = wd;
      @(posedge clk);
      #1;
   endtask

   task automatic restart();
      step(1'b1, IPC, NOP, 1'b0, 5'd0, 32'd0);
      step(1'b1, IPC, NOP, 1'b0, 5'd0, 32'd0);
      step(1'b0, IPC, NOP, 1'b0, 5'd0, 32'd0);
   endtask

   initial begin
      //       r     pc     instr we  wa     wd        st cs cy rt wv
      tbl[0] = '{1'b1, IPC,  NOP, 0, 5'd0,  32'h0,  2'd0, 2'd0, 0, 0, 32'h0};
      tbl[1] = '{1'b1, IPC,  NOP, 0, 5'd0,  32'h0,  2'd0, 2'd0, 0, 0, 32'h0};
      tbl[2] = '{1'b0, IPC,  NOP, 0, 5'd0,  32'h0,  2'd1, 2'd0, 0, 0, 32'h0};
      tbl[3] = '{1'b0, 32'd0, NOP, 1, 5'd11, 32'h2A, 2'd1, 2'd0, 1, 1, 32'h2A};
      tbl[4] = '{1'b0, 32'd4, NOP, 1, 5'd10, 32'h55, 2'd1, 2'd0, 2, 2, 32'h2A};
      tbl[5] = '{1'b0, 32'd8, NOP, 1, 5'd0,  32'h77, 2'd1, 2'd0, 3, 3, 32'h2A};
      tbl[6] = '{1'b0, 32'd12, NOP, 0, 5'd0, 32'h0,  2'd1, 2'd0, 4, 4, 32'h2A};
      tbl[7] = '{1'b0, 32'd16, ECL, 0, 5'd0, 32'h0,  2'd2, 2'd1, 5, 5, 32'h2A};
      tbl[8] = '{1'b0, 32'd20, NOP, 1, 5'd11, 32'h99, 2'd2, 2'd1, 5, 5, 32'h2A};
      tbl[9] = '{1'b0, 32'd24, NOP, 0, 5'd0, 32'h0,  2'd2, 2'd1, 5, 5, 32'h2A};

      for (int i = 0; i < 10; i++) begin
         step(tbl[i].r, tbl[i].p, tbl[i].ins, tbl[i].we,
              tbl[i].wa, tbl[i].wd);
         chk($sformatf("v%0d state", i), 32'(state), 32'(tbl[i].st));
         chk($sformatf("v%0d cause", i), 32'(halt_cause), 32'(tbl[i].cs));
         chk($sformatf("v%0d cycles", i), cycle_count, tbl[i].cy);
         chk($sformatf("v%0d instret", i), instret, tbl[i].rt);
         chk($sformatf("v%0d watch", i), watch_value, tbl[i].wv);
         chk($sformatf("v%0d done", i), 32'(done),
             (tbl[i].st >= 2'd2) ? 32'd1 : 32'd0);
      end
      chk("x0 watch", z_watch, 32'd0);
`ifdef MON_EXPECT_EN
      chk("mismatch pass", 32'(pass), 32'd0);
      chk("mismatch fail", 32'(fail), 32'd1);

      restart();
      step(1'b0, 32'd0, NOP, 1'b1, 5'd11, 32'd55);
      step(1'b0, 32'd4, ECL, 1'b0, 5'd0, 32'd0);
      chk("match pass", 32'(pass), 32'd1);
      chk("match fail", 32'(fail), 32'd0);
`endif

      // EBREAK halt
      restart();
      step(1'b0, 32'd0, NOP, 1'b0, 5'd0, 32'd0);
      step(1'b0, 32'd4, EBK, 1'b0, 5'd0, 32'd0);
      chk("ebreak state", 32'(state), 32'd2);
      chk("ebreak cause", 32'(halt_cause), 32'd2);
      chk("ebreak cycles", cycle_count, 32'd2);

      // self-loop at pc 8
      restart();
      step(1'b0, 32'd0, NOP, 1'b0, 5'd0, 32'd0);
      step(1'b0, 32'd4, NOP, 1'b0, 5'd0, 32'd0);
      step(1'b0, 32'd8, NOP, 1'b0, 5'd0, 32'd0);
      step(1'b0, 32'd8, NOP, 1'b0, 5'd0, 32'd0);
      step(1'b0, 32'd8, NOP, 1'b0, 5'd0, 32'd0);
      chk("loop pre state", 32'(state), 32'd1);
      step(1'b0, 32'd8, NOP, 1'b0, 5'd0, 32'd0);
      chk("loop state", 32'(state), 32'd2);
      chk("loop cause", 32'(halt_cause), 32'd3);
      chk("loop instret", instret, 32'd3);
      chk("loop cycles", cycle_count, 32'd6);
      trace_idx = 3'd0; #1;
      chk("loop trace0", trace_pc, 32'd8);
      trace_idx = 3'd1; #1;
      chk("loop trace1", trace_pc, 32'd4);
      trace_idx = 3'd2; #1;
      chk("loop trace2", trace_pc, 32'd0);
      trace_idx = 3'd3; #1;
      chk("loop trace3", trace_pc, 32'd0);

      // timeout with ever-changing pc
      restart();
      for (int k = 0; k < 49; k++)
         step(1'b0, 32'(4 * k), NOP, 1'b0, 5'd0, 32'd0);
      chk("tmo pre state", 32'(state), 32'd1);
      chk("tmo pre cycles", cycle_count, 32'd49);
      step(1'b0, 32'd196, NOP, 1'b0, 5'd0, 32'd0);
      chk("tmo state", 32'(state), 32'd3);
      chk("tmo cycles", cycle_count, 32'd50);
      chk("tmo cause", 32'(halt_cause), 32'd0);
      chk("tmo done", 32'(done), 32'd1);
      for (int k = 0; k < 4; k++)
         step(1'b0, 32'(400 + 4 * k), NOP, 1'b0, 5'd0, 32'd0);
      chk("tmo frozen cyc", cycle_count, 32'd50);
      chk("tmo frozen ret", instret, 32'd50);
      chk("tmo frozen st", 32'(state), 32'd3);
`ifdef MON_EXPECT_EN
      chk("tmo fail", 32'(fail), 32'd1);
      chk("tmo pass", 32'(pass), 32'd0);
`endif

      // history wrap with 12 PCs, then reset mid-run
      restart();
      for (int k = 0; k < 12; k++)
         step(1'b0, 32'(256 + 4 * k), NOP, 1'b0, 5'd0, 32'd0);
      for (int i = 0; i < 8; i++) begin
         trace_idx = 3'(i); #1;
         chk($sformatf("wrap trace%0d", i), trace_pc,
             32'(256 + 4 * (11 - i)));
      end
      step(1'b1, 32'd300, NOP, 1'b0, 5'd0, 32'd0);
      trace_idx = 3'd0; #1;
      chk("rst state", 32'(state), 32'd0);
      chk("rst cycles", cycle_count, 32'd0);
      chk("rst instret", instret, 32'd0);
      chk("rst watch", watch_value, 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst trace", trace_pc, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
